sweep_timer: RTL and testbench

Multi-axis sweep timing recorder/replayer for the solar tracker. For each servo axis it measures how long a sweep command is held (record), stores that length, and later produces a RUN window of exactly the same length (replay) while the FSM searches for the maximum. Unlike the single-axis max counter, the stored length survives replay, counts saturate instead of wrapping, and a prescaled tick is supported. It sits between the tracker FSM and the PWM generators, with one channel per axis.

---
 rtl/sweep_timer.sv | 144 ++++++++++++++
 tb/tb_sweep_timer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_timer.sv
// rtl/sweep_timer.sv - per-axis sweep duration recorder/replayer with shared prescaler
module sweep_timer #(
    parameter int WIDTH    = 15,
    parameter int N_AXIS   = 2,
    parameter int PRESCALE = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [N_AXIS-1:0]         CLR,
    input  logic [N_AXIS-1:0]         REC,
    input  logic [N_AXIS-1:0]         PLAY,
    output logic [N_AXIS-1:0]         RUN,
    output logic [N_AXIS-1:0]         DONE,
    output logic [N_AXIS-1:0]         VALID,
    output logic [N_AXIS-1:0]         OVF,
    output logic [N_AXIS*WIDTH-1:0]   LEN
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] LEN_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECORD,
        S_HOLD,
        S_REPLAY
    } state_t;

    logic [PW-1:0] pre_q;
    logic          tick;

    // With PRESCALE=1 the counter sits at zero and tick is constantly high.
    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    for (genvar i = 0; i < N_AXIS; i++) begin : g_axis
        state_t           state_q, state_d;
        logic [WIDTH-1:0] len_q, len_d;
        logic [WIDTH-1:0] rem_q, rem_d;
        logic             valid_q, valid_d;
        logic             ovf_q, ovf_d;
        logic             run_q, run_d;
        logic             done_q, done_d;

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state_q <= S_IDLE;
                len_q   <= '0;
                rem_q   <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
                run_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                len_q   <= len_d;
                rem_q   <= rem_d;
                valid_q <= valid_d;
                ovf_q   <= ovf_d;
                run_q   <= run_d;
                done_q  <= done_d;
            end
        end

        // Priority CLR > REC > PLAY; RUN and DONE are registered copies of the next-state decision.
        always_comb begin
            state_d = state_q;
            len_d   = len_q;
            rem_d   = rem_q;
            valid_d = valid_q;
            ovf_d   = ovf_q;
            run_d   = 1'b0;
            done_d  = 1'b0;
            if (CLR[i]) begin
                state_d = S_IDLE;
                len_d   = '0;
                rem_d   = '0;
                valid_d = 1'b0;
                ovf_d   = 1'b0;
            end else if (REC[i]) begin
                if (state_q == S_RECORD) begin
                    if (tick && (len_q != LEN_MAX)) begin
                        len_d = len_q + WIDTH'(1);
                        if (len_d == LEN_MAX) begin
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_RECORD;
                    len_d   = '0;
                    rem_d   = '0;
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end else begin
                case (state_q)
                    S_RECORD: begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                    end
                    S_IDLE, S_HOLD: begin
                        if (PLAY[i]) begin
                            rem_d = len_q;
                            if (len_q != '0) begin
                                state_d = S_REPLAY;
                                run_d   = 1'b1;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end
                    S_REPLAY: begin
                        run_d = 1'b1;
                        if (tick) begin
                            rem_d = rem_q - WIDTH'(1);
                            if (rem_q == WIDTH'(1)) begin
                                run_d   = 1'b0;
                                done_d  = 1'b1;
                                state_d = valid_q ? S_HOLD : S_IDLE;
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        assign RUN[i]                 = run_q;
        assign DONE[i]                = done_q;
        assign VALID[i]               = valid_q;
        assign OVF[i]                 = ovf_q;
        assign LEN[i*WIDTH +: WIDTH]  = len_q;
    end

endmodule

// File: tb/tb_sweep_timer.sv
// tb/tb_sweep_timer.sv - table-driven and directed checks of sweep_timer
module tb_sweep_timer;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    // dut_a: WIDTH=15, two axes, PRESCALE=1
    logic [1:0]  clr_a = '0, rec_a = '0, play_a = '0;
    logic [1:0]  run_a, done_a, valid_a, ovf_a;
    logic [29:0] len_a;

    // dut_s: WIDTH=4, one axis, PRESCALE=1
    logic [0:0]  clr_s = '0, rec_s = '0, play_s = '0;
    logic [0:0]  run_s, done_s, valid_s, ovf_s;
    logic [3:0]  len_s;

    // dut_p: WIDTH=8, two axes, PRESCALE=4
    logic [1:0]  clr_p = '0, rec_p = '0, play_p = '0;
    logic [1:0]  run_p, done_p, valid_p, ovf_p;
    logic [15:0] len_p;

    sweep_timer #(.WIDTH(15), .N_AXIS(2), .PRESCALE(1)) dut_a (
        .CLK(CLK), .RESET(RESET), .CLR(clr_a), .REC(rec_a), .PLAY(play_a),
        .RUN(run_a), .DONE(done_a), .VALID(valid_a), .OVF(ovf_a), .LEN(len_a)
    );

    sweep_timer #(.WIDTH(4), .N_AXIS(1), .PRESCALE(1)) dut_s (
        .CLK(CLK), .RESET(RESET), .CLR(clr_s), .REC(rec_s), .PLAY(play_s),
        .RUN(run_s), .DONE(done_s), .VALID(valid_s), .OVF(ovf_s), .LEN(len_s)
    );

    sweep_timer #(.WIDTH(8), .N_AXIS(2), .PRESCALE(4)) dut_p (
        .CLK(CLK), .RESET(RESET), .CLR(clr_p), .REC(rec_p), .PLAY(play_p),
        .RUN(run_p), .DONE(done_p), .VALID(valid_p), .OVF(ovf_p), .LEN(len_p)
    );

    int n_pass = 0;
    int n_total = 0;

    int m_run[2];
    int m_fall[2];
    int m_dcnt[2];
    int m_didx[2];

    typedef struct {
        logic [1:0]  clr, rec, play;
        logic [1:0]  run, done, valid, ovf;
        logic [14:0] len0, len1;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] c, r, p, ru, dn, va, ov, input int l0, l1);
        vec_t v;
        v.clr = c; v.rec = r; v.play = p;
        v.run = ru; v.done = dn; v.valid = va; v.ovf = ov;
        v.len0 = 15'(l0); v.len1 = 15'(l1);
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [1:0] get_run(input int sel);
        case (sel)
            0:       return {1'b0, run_a[0]};
            1:       return {1'b0, run_s[0]};
            default: return run_p;
        endcase
    endfunction

    function automatic logic [1:0] get_done(input int sel);
        case (sel)
            0:       return {1'b0, done_a[0]};
            1:       return {1'b0, done_s[0]};
            default: return done_p;
        endcase
    endfunction

    // Pulse PLAY once, then observe RUN/DONE for a bounded number of cycles.
    // Index 0 is the cycle right after the PLAY edge.
    task automatic measure(input int sel);
        logic [1:0] r, d;
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_fall[k] = -1; m_dcnt[k] = 0; m_didx[k] = -1;
        end
        case (sel)
            0:       play_a = 2'b01;
            1:       play_s = 1'b1;
            default: play_p = 2'b11;
        endcase
        step();
        play_a = '0; play_s = '0; play_p = '0;
        for (int c = 0; c < 300; c++) begin
            r = get_run(sel);
            d = get_done(sel);
            for (int k = 0; k < 2; k++) begin
                if (r[k]) m_run[k]++;
                else if (m_fall[k] < 0) m_fall[k] = c;
                if (d[k]) begin
                    m_dcnt[k]++;
                    m_didx[k] = c;
                end
            end
            step();
        end
    endtask

    // The first REC edge only enters RECORD, so n edges of REC give length n-1.
    task automatic record_a0(input int edges);
        rec_a = 2'b01;
        repeat (edges) step();
        rec_a = 2'b00;
        step();
    endtask

    initial begin
        logic ok;
        int   cyc;

        // clr, rec, play | run, done, valid, ovf, len0, len1
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0));
        tbl.push_back(mk(2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2, 0));
        tbl.push_back(mk(2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 3, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 3, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 3, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 3, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 3, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 3, 0));
        tbl.push_back(mk(2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 1, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 1, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1, 0));
        tbl.push_back(mk(2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 1));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 0, 1));
        tbl.push_back(mk(2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 0, 0));
        tbl.push_back(mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 0, 0));
        tbl.push_back(mk(2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0));

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        foreach (tbl[i]) begin
            clr_a = tbl[i].clr; rec_a = tbl[i].rec; play_a = tbl[i].play;
            step();
            check($sformatf("vec%0d", i),
                  64'({run_a, done_a, valid_a, ovf_a, len_a[14:0], len_a[29:15]}),
                  64'({tbl[i].run, tbl[i].done, tbl[i].valid, tbl[i].ovf, tbl[i].len0, tbl[i].len1}));
        end
        clr_a = '0; rec_a = '0; play_a = '0;

        // 100-tick recording and two identical replay windows
        record_a0(101);
        check("a0 len100", 64'(len_a[14:0]), 64'd100);
        check("a0 valid", 64'(valid_a[0]), 64'd1);
        for (int rep = 0; rep < 2; rep++) begin
            measure(0);
            check($sformatf("a0 run cycles r%0d", rep), 64'(m_run[0]), 64'd100);
            check($sformatf("a0 run fall r%0d", rep), 64'(m_fall[0]), 64'd100);
            check($sformatf("a0 done count r%0d", rep), 64'(m_dcnt[0]), 64'd1);
            check($sformatf("a0 done index r%0d", rep), 64'(m_didx[0]), 64'd100);
            check($sformatf("a0 len kept r%0d", rep), 64'(len_a[14:0]), 64'd100);
        end

        // REC during replay aborts it and restarts the recording
        clr_a = 2'b01; step(); clr_a = '0;
        record_a0(51);
        check("a0 len50", 64'(len_a[14:0]), 64'd50);
        play_a = 2'b01; step(); play_a = '0;
        repeat (19) step();
        check("abort run before", 64'(run_a[0]), 64'd1);
        rec_a = 2'b01; step();
        check("abort edge", 64'({run_a[0], done_a[0], valid_a[0], len_a[14:0]}), 64'd0);
        step();
        check("abort next", 64'({run_a[0], done_a[0], len_a[14:0]}), 64'd1);
        rec_a = '0; step();

        // asynchronous reset in the middle of a replay
        clr_a = 2'b01; step(); clr_a = '0;
        record_a0(11);
        play_a = 2'b01; step(); play_a = '0;
        step();
        check("pre-reset run", 64'(run_a[0]), 64'd1);
        #3 RESET = 1'b1;
        #1;
        check("async reset", 64'({run_a, done_a, valid_a, ovf_a, len_a}), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            step();
            if ({run_a, done_a, valid_a, ovf_a, len_a} !== '0) ok = 1'b0;
        end
        check("quiet after reset", 64'(ok), 64'd1);

        // saturation with WIDTH=4
        rec_s = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e == 15) check("sat e15", 64'({ovf_s, len_s}), 64'({1'b0, 4'd14}));
            if (e == 16) check("sat e16", 64'({ovf_s, len_s}), 64'({1'b1, 4'd15}));
        end
        rec_s = 1'b0;
        step();
        check("sat hold", 64'({valid_s, ovf_s, len_s}), 64'({1'b1, 1'b1, 4'd15}));
        measure(1);
        check("sat run cycles", 64'(m_run[0]), 64'd15);
        check("sat done", 64'({m_dcnt[0][7:0], m_didx[0][7:0]}), 64'({8'd1, 8'd15}));
        clr_s = 1'b1; step(); clr_s = 1'b0;
        check("sat clr", 64'({run_s, done_s, valid_s, ovf_s, len_s}), 64'd0);

        // prescaled, independent axes: axis0 records 10 ticks, axis1 records 3
        rec_p = 2'b11;
        cyc = 0;
        while (rec_p != 2'b00 && cyc < 200) begin
            step();
            cyc++;
            if (rec_p[1] && len_p[15:8] == 8'd3) rec_p[1] = 1'b0;
            if (rec_p[0] && len_p[7:0] == 8'd10) rec_p[0] = 1'b0;
        end
        rec_p = 2'b00;
        step();
        check("p record bounded", 64'(cyc < 200), 64'd1);
        check("p lens", 64'(len_p), 64'({8'd3, 8'd10}));
        check("p valid", 64'(valid_p), 64'd3);
        measure(2);
        check("p run0 window", 64'(m_run[0] >= 37 && m_run[0] <= 40), 64'd1);
        check("p fall gap", 64'(m_fall[0] - m_fall[1]), 64'd28);
        check("p done counts", 64'({m_dcnt[1][7:0], m_dcnt[0][7:0]}), 64'({8'd1, 8'd1}));
        check("p done0 at fall", 64'(m_didx[0] == m_fall[0]), 64'd1);
        check("p done1 at fall", 64'(m_didx[1] == m_fall[1]), 64'd1);
        check("p lens kept", 64'(len_p), 64'({8'd3, 8'd10}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
